// File: rtl/train_sequencer.sv
// -----------------------------------------------------------------------------
// train_sequencer
//
// Master step sequencer of the train controller. It owns the 16-step route
// index and the dwell timer. It periodically strobes the condition
// synchronizer, samples the returned condition and advances the route index
// when the condition holds.
//
// Poll cycle: REQ (Enable strobe) -> SETTLE -> CHECK (sample Y) -> GAP.
// GAP lasts POLL_CYCLES cycles. The poll period is therefore 3 + POLL_CYCLES.
//
// Parameters
//   DWELL_CYCLES : cycles from step entry (or reset release) until TIMER rises
//   POLL_CYCLES  : idle cycles between consecutive polls (>= 1)
//   CW           : dwell counter width
//
// Ports
//   CLK      in   system clock, rising edge
//   RST_N    in   asynchronous active-low reset
//   Run      in   sequencing permitted (sampled in IDLE and at end of GAP)
//   Y        in   condition result from the synchronizer (sampled in CHECK)
//   Selector out  current step index 0..15
//   Enable   out  one-cycle evaluation strobe
//   TIMER    out  dwell elapsed in current step (level, saturating)
//   Advance  out  one-cycle pulse in the first cycle a new Selector is visible
//   Busy     out  FSM not in IDLE
//
// All outputs come straight from flops; Y and Run only reach the outputs
// through the next-state logic.
// -----------------------------------------------------------------------------
module train_sequencer #(
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned POLL_CYCLES  = 4,
  parameter int unsigned CW           = 24
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       Run,
  input  logic       Y,
  output logic [3:0] Selector,
  output logic       Enable,
  output logic       TIMER,
  output logic       Advance,
  output logic       Busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    GAP    = 3'd4
  } state_e;

  // The gap counter runs 0 .. POLL_CYCLES-1.
  localparam int GW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST  = GW'(POLL_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_MAX = CW'(DWELL_CYCLES);

  state_e          state_q, state_d;
  logic [GW-1:0]   gap_q,   gap_d;
  logic [3:0]      sel_q,   sel_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic            timer_q, timer_d;
  logic            adv_q,   adv_d;
  logic            en_q,    en_d;
  logic            busy_q,  busy_d;
  logic            advance_now;

  // An advance is decided at the edge that ends CHECK.
  assign advance_now = (state_q == CHECK) && Y;

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    sel_d   = sel_q;
    adv_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Run) state_d = REQ;
      end
      REQ: begin
        state_d = SETTLE;
      end
      SETTLE: begin
        state_d = CHECK;
      end
      CHECK: begin
        gap_d   = '0;
        state_d = GAP;
        if (Y) begin
          sel_d = sel_q + 4'd1;
          adv_d = 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = Run ? REQ : IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gap_d   = '0;
      end
    endcase

    // Dwell counter runs in every state. An advance in the same cycle as
    // saturation wins, so the counter restarts from zero.
    if (advance_now) begin
      cnt_d = '0;
    end else if (cnt_q != DWELL_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end

    // TIMER, Enable and Busy are registered copies of what the next state
    // implies, so they line up with the state they describe.
    timer_d = (cnt_d == DWELL_MAX);
    en_d    = (state_d == REQ);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      gap_q   <= '0;
      sel_q   <= 4'd0;
      cnt_q   <= '0;
      timer_q <= 1'b0;
      adv_q   <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      adv_q   <= adv_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
    end
  end

  assign Selector = sel_q;
  assign Enable   = en_q;
  assign TIMER    = timer_q;
  assign Advance  = adv_q;
  assign Busy     = busy_q;

endmodule

// File: tb/tb_train_sequencer.sv
// -----------------------------------------------------------------------------
// tb_train_sequencer
//
// Directed bench for train_sequencer. u_dut uses the default parameters
// (DWELL_CYCLES=1000, POLL_CYCLES=4); u_dut10 uses DWELL_CYCLES=10 for the
// TIMER loop-back scenario, with its Y driven from its own TIMER in step 2.
// Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_train_sequencer;

  logic       clk;
  logic       rst_n, run, y;
  logic [3:0] sel;
  logic       en, timer, adv, busy;

  logic       rst10_n, run10, y10;
  logic [3:0] sel10;
  logic       en10, timer10, adv10, busy10;

  int n_cmp  = 0;
  int n_fail = 0;
  int since_adv = 0;   // cycles since reset release / last advance of u_dut

  train_sequencer u_dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .Run      (run),
    .Y        (y),
    .Selector (sel),
    .Enable   (en),
    .TIMER    (timer),
    .Advance  (adv),
    .Busy     (busy)
  );

  train_sequencer #(.DWELL_CYCLES(10), .POLL_CYCLES(4), .CW(24)) u_dut10 (
    .CLK      (clk),
    .RST_N    (rst10_n),
    .Run      (run10),
    .Y        (y10),
    .Selector (sel10),
    .Enable   (en10),
    .TIMER    (timer10),
    .Advance  (adv10),
    .Busy     (busy10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle; also refresh the loop-back Y of u_dut10.
  task automatic tick();
    @(posedge clk);
    #1;
    since_adv++;
    y10 = (sel10 == 4'd2) ? timer10 : 1'b1;
  endtask

  // One full poll of u_dut starting from a state whose next edge enters REQ.
  task automatic poll(input logic [3:0] sb, input logic a);
    logic [3:0] sa;
    sa = a ? sb + 4'd1 : sb;
    tick();
    chk1("req_enable", en, 1'b1);
    chk4("req_sel", sel, sb);
    chk1("req_busy", busy, 1'b1);
    chk1("req_timer", timer, since_adv >= 1000);
    tick();
    chk1("settle_enable", en, 1'b0);
    tick();
    chk4("check_sel", sel, sb);
    chk1("check_adv", adv, 1'b0);
    tick();
    if (a) since_adv = 0;
    chk4("adv_sel", sel, sa);
    chk1("adv_pulse", adv, a);
    chk1("adv_timer", timer, since_adv >= 1000);
    chk1("adv_enable", en, 1'b0);
    repeat (3) begin
      tick();
      chk1("gap_adv", adv, 1'b0);
      chk1("gap_enable", en, 1'b0);
      chk1("gap_timer", timer, since_adv >= 1000);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    run     = 1'b0;
    y       = 1'b0;
    rst10_n = 1'b0;
    run10   = 1'b0;
    y10     = 1'b1;

    // Reset values while reset is held
    repeat (3) tick();
    chk4("rst_sel", sel, 4'd0);
    chk1("rst_enable", en, 1'b0);
    chk1("rst_timer", timer, 1'b0);
    chk1("rst_adv", adv, 1'b0);
    chk1("rst_busy", busy, 1'b0);

    // Scenario 1: Run=0 after reset release; TIMER rises at cycle 1000
    rst_n = 1'b1;
    since_adv = 0;
    repeat (20) begin
      tick();
      chk4("idle_sel", sel, 4'd0);
      chk1("idle_enable", en, 1'b0);
      chk1("idle_busy", busy, 1'b0);
    end
    while (since_adv < 999) tick();
    chk1("timer_999", timer, 1'b0);
    tick();
    chk1("timer_1000", timer, 1'b1);
    tick();
    chk1("timer_hold", timer, 1'b1);

    // Scenario 2: Run=1, Y=1: step every 7 cycles, 15 wraps to 0
    run = 1'b1;
    y   = 1'b1;
    for (int k = 0; k < 17; k++) poll(4'(k), 1'b1);

    // Scenario 3: Y=0: polls continue, Selector frozen, TIMER sets and holds
    y = 1'b0;
    for (int k = 0; k < 150; k++) poll(4'd1, 1'b0);
    chk1("timer_held_y0", timer, 1'b1);

    // Scenario 5: drop Run in the REQ cycle with Y=1
    y = 1'b1;
    tick();
    chk1("drop_req_enable", en, 1'b1);
    run = 1'b0;
    tick();
    tick();
    chk4("drop_check_sel", sel, 4'd1);
    tick();
    since_adv = 0;
    chk4("drop_adv_sel", sel, 4'd2);
    chk1("drop_adv_pulse", adv, 1'b1);
    chk1("drop_adv_timer", timer, 1'b0);
    repeat (3) begin
      tick();
      chk1("drop_gap_busy", busy, 1'b1);
      chk1("drop_gap_adv", adv, 1'b0);
    end
    tick();
    chk1("drop_idle_busy", busy, 1'b0);
    repeat (20) begin
      tick();
      chk1("drop_no_enable", en, 1'b0);
      chk1("drop_idle_busy2", busy, 1'b0);
    end

    // Scenario 6: asynchronous reset during SETTLE with Y=1
    run = 1'b1;
    y   = 1'b1;
    tick();
    chk1("arst_req_enable", en, 1'b1);
    tick();
    chk1("arst_settle_busy", busy, 1'b1);
    chk4("arst_settle_sel", sel, 4'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk4("arst_now_sel", sel, 4'd0);
    chk1("arst_now_enable", en, 1'b0);
    chk1("arst_now_busy", busy, 1'b0);
    chk1("arst_now_adv", adv, 1'b0);
    chk1("arst_now_timer", timer, 1'b0);
    run = 1'b0;
    repeat (2) begin
      tick();
      chk4("arst_hold_sel", sel, 4'd0);
      chk1("arst_hold_adv", adv, 1'b0);
    end
    rst_n = 1'b1;
    since_adv = 0;
    repeat (10) begin
      tick();
      chk4("arst_after_sel", sel, 4'd0);
      chk1("arst_after_adv", adv, 1'b0);
      chk1("arst_after_busy", busy, 1'b0);
    end

    // Scenario 4: TIMER loop-back on u_dut10 (DWELL_CYCLES=10)
    rst10_n = 1'b1;
    run10   = 1'b1;
    tick();                                   // edge 1: REQ
    chk1("lb_enable", en10, 1'b1);
    chk1("lb_busy", busy10, 1'b1);
    repeat (9) tick();                        // edge 10
    tick();                                   // edge 11: enter step 2
    chk4("lb_enter2_sel", sel10, 4'd2);
    chk1("lb_enter2_adv", adv10, 1'b1);
    repeat (6) tick();                        // edge 17: CHECK, dwell 6
    chk1("lb_check1_timer", timer10, 1'b0);
    tick();                                   // edge 18: no advance
    chk4("lb_noadv_sel", sel10, 4'd2);
    chk1("lb_noadv_adv", adv10, 1'b0);
    repeat (2) tick();                        // edge 20
    chk1("lb_timer_9", timer10, 1'b0);
    tick();                                   // edge 21
    chk1("lb_timer_10", timer10, 1'b1);
    repeat (3) tick();                        // edge 24: CHECK with TIMER=1
    chk4("lb_check2_sel", sel10, 4'd2);
    chk1("lb_check2_timer", timer10, 1'b1);
    tick();                                   // edge 25: advance 2 -> 3
    chk4("lb_adv_sel", sel10, 4'd3);
    chk1("lb_adv_pulse", adv10, 1'b1);
    chk1("lb_adv_timer", timer10, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
